sigbuff_ctrl: RTL and testbench
===============================

# sigbuff_ctrl

Signal buffer controller for the iterative reconstruction datapath. It stores one frame of up to MAX_SAMPLES_IN_RAM samples in a circular on-chip RAM. On the first iteration it is written from the level generator; on later iterations it is written from the hard-limiter feedback. It streams the stored frame to the FIR front end under control of the iteration controller's sigbuff_* signals.

## Interface
- MAX_SAMPLES_IN_RAM, 255: buffer depth in samples (2..256, any value, not only a power of two).
- DATA_WIDTH, 16: sample width in bits.
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; clears all state.
- sigbuff_iter_num  in  5  current iteration index from the iteration controller.
- sigbuff_input_mux  in  1  write source: 0 = level generator, 1 = limiter.
- sigbuff_input_enable  in  1  write permission.
- sigbuff_output_enable  in  1  read permission.
- lvl_gen_data  in  DATA_WIDTH  level generator sample.
- lvl_gen_valid  in  1  lvl_gen_data valid.
- limiter_data  in  DATA_WIDTH  limiter feedback sample.
- limiter_valid  in  1  limiter_data valid.
- sigbuff_ready  out  1  buffer can accept a write this cycle.
- fir_data  out  DATA_WIDTH  sample read from the buffer.
- fir_valid  out  1  fir_data valid, one-cycle pulse per sample.
- fir_iter_num  out  5  iteration tag aligned with fir_data.
- sigbuff_count  out  $clog2(MAX_SAMPLES_IN_RAM+1)  current fill level.
- sigbuff_overflow  out  1  sticky flag: a write was dropped.

## Operation
- State: wr_ptr and rd_ptr, each in 0..MAX_SAMPLES_IN_RAM-1; count in 0..MAX_SAMPLES_IN_RAM; overflow flag; output registers.
- Selected valid is lvl_gen_valid when input_mux=0 and limiter_valid when input_mux=1. Selected data follows the same mux.
- Write request: input_enable & selected valid.
- Read request: output_enable & (count != 0).
- Write accepted: write request & (count < MAX_SAMPLES_IN_RAM or read request in the same cycle).
- A write request that is not accepted drops its sample and sets overflow. Overflow is cleared only by reset.
- Pointers increment on an accepted write or read. At MAX_SAMPLES_IN_RAM-1 they wrap to 0; there is no modulo arithmetic on a power of two.
- Count changes by +1 on a write only, -1 on a read only, and 0 when both happen in the same cycle.
- sigbuff_ready = (count < MAX_SAMPLES_IN_RAM) | (output_enable & count != 0). This is combinational from registered count and input output_enable.
- Empty buffer with a simultaneous write: no read happens that cycle. The sample becomes readable on the next cycle; there is no bypass.
- fir_iter_num is sigbuff_iter_num sampled on the read-request cycle and delayed to align with fir_data.
- A change of input_mux or iter_num does not alter the pointers. The frame stays continuous across iterations.

## Timing
- Reset values: sigbuff_ready=1, fir_data=0, fir_valid=0, fir_iter_num=0, sigbuff_count=0, sigbuff_overflow=0. RAM contents are undefined.
- Read latency is 1 cycle: a read request in cycle N gives fir_valid=1 with that data in cycle N+1.
- Write-to-read latency: a sample written in cycle N can be read in cycle N+1 and appears on fir_data in cycle N+2.
- Throughput is 1 read and 1 write per cycle, sustained.
- Reset asserted mid-frame: all outputs return to reset values immediately, asynchronously. Any in-flight fir_valid is lost.
- No combinational path from lvl_gen_data or limiter_data to outputs.

## Structure
- Package sigbuff_pkg holds:
  - the typedef for source select (SRC_LVL_GEN=0, SRC_LIMITER=1);
  - a ptr_next(ptr, depth) wrap function;
  - the clog2-based width constants shared with the limbuff controller.
- One sub-module, sigbuff_sdp_ram: simple dual-port RAM with one write port and one registered read port, parameterised by depth and width, inferable as an M10K block.

## Test plan
- Fill and drain: input_mux=0, write 255 samples 0..254 with output_enable=0 -> count=255 and ready=0. Then output_enable=1 -> fir_data 0..254 on consecutive cycles, with the first fir_valid one cycle after enable.
- Overflow: with count=255 and output_enable=0, pulse lvl_gen_valid with data 0xABCD -> sample dropped, overflow=1 and stays 1, count stays 255.
- Full with simultaneous read/write: with count=255, output_enable=1 and limiter_valid=1 with input_mux=1 for 10 cycles -> count stays 255, overflow=0, all 10 writes stored.
- Wrap: MAX_SAMPLES_IN_RAM=5; write 3, read 3, write 5 samples (values 10..14) -> pointers wrap through 0, and the read-back order is 10..14.
- Iteration tag: sigbuff_iter_num changes 0->1 between two reads -> fir_iter_num is 0 then 1, each aligned with its fir_valid.
- Async reset mid-stream: assert reset between clock edges during streaming -> fir_valid=0 and count=0 immediately. After release, ready=1 and the first write is read back correctly.

Source files
------------

// File: rtl/sigbuff_pkg.sv
// Shared types and width helpers for the signal/limiter buffer controllers.
package sigbuff_pkg;

  // Write-source select driven by sigbuff_input_mux.
  typedef enum logic {
    SRC_LVL_GEN = 1'b0,
    SRC_LIMITER = 1'b1
  } src_sel_e;

  // Iteration tag width used across the reconstruction datapath.
  localparam int unsigned ITER_W = 5;

  // Address width for a buffer of 'depth' entries (at least one bit).
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 32'd1) ? $clog2(depth) : 32'd1;
  endfunction

  // Fill-level width: must represent 0..depth inclusive.
  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth + 32'd1);
  endfunction

  // Circular increment with an explicit wrap, so any depth works.
  function automatic int unsigned ptr_next(input int unsigned ptr,
                                           input int unsigned depth);
    return (ptr >= depth - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/sigbuff_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
module sigbuff_sdp_ram
  import sigbuff_pkg::*;
#(
  parameter  int unsigned DEPTH = 255,
  parameter  int unsigned WIDTH = 16,
  localparam int unsigned AW    = ptr_width(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // Storage array: no reset, so it maps onto block RAM.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read register: returns the pre-write contents when read and write hit
  // the same address (full buffer with simultaneous read/write). It carries
  // the async reset so the output reads zero out of reset; it holds its value
  // between reads.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)      rd_data_q <= '0;
    else if (rd_en) rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/sigbuff_ctrl.sv
// Signal buffer controller: circular frame store between the level
// generator / limiter feedback and the FIR front end.
module sigbuff_ctrl
  import sigbuff_pkg::*;
#(
  parameter  int unsigned MAX_SAMPLES_IN_RAM = 255,
  parameter  int unsigned DATA_WIDTH         = 16,
  localparam int unsigned PTR_W              = ptr_width(MAX_SAMPLES_IN_RAM),
  localparam int unsigned CNT_W              = count_width(MAX_SAMPLES_IN_RAM)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ITER_W-1:0]     sigbuff_iter_num,
  input  logic                  sigbuff_input_mux,
  input  logic                  sigbuff_input_enable,
  input  logic                  sigbuff_output_enable,
  input  logic [DATA_WIDTH-1:0] lvl_gen_data,
  input  logic                  lvl_gen_valid,
  input  logic [DATA_WIDTH-1:0] limiter_data,
  input  logic                  limiter_valid,
  output logic                  sigbuff_ready,
  output logic [DATA_WIDTH-1:0] fir_data,
  output logic                  fir_valid,
  output logic [ITER_W-1:0]     fir_iter_num,
  output logic [CNT_W-1:0]      sigbuff_count,
  output logic                  sigbuff_overflow
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(MAX_SAMPLES_IN_RAM);

  src_sel_e              src_sel;
  logic                  sel_valid;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  not_full;
  logic                  wr_req;
  logic                  rd_req;
  logic                  wr_acc;

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  fir_valid_q, fir_valid_d;
  logic [ITER_W-1:0]     fir_iter_q, fir_iter_d;

  // Source mux and read/write request/accept decisions.
  always_comb begin
    src_sel = src_sel_e'(sigbuff_input_mux);
    case (src_sel)
      SRC_LIMITER: begin
        sel_valid = limiter_valid;
        sel_data  = limiter_data;
      end
      default: begin
        sel_valid = lvl_gen_valid;
        sel_data  = lvl_gen_data;
      end
    endcase
    not_full = (count_q < DEPTH_C);
    rd_req   = sigbuff_output_enable && (count_q != '0);
    wr_req   = sigbuff_input_enable && sel_valid;
    // A read in the same cycle frees a slot, so a full buffer still accepts.
    wr_acc   = wr_req && (not_full || rd_req);
  end

  // Next-state for pointers, fill level, sticky overflow and output tags.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    fir_valid_d = rd_req;
    fir_iter_d  = fir_iter_q;

    if (wr_acc) wr_ptr_d = PTR_W'(ptr_next(32'(wr_ptr_q), MAX_SAMPLES_IN_RAM));
    if (rd_req) begin
      rd_ptr_d   = PTR_W'(ptr_next(32'(rd_ptr_q), MAX_SAMPLES_IN_RAM));
      fir_iter_d = sigbuff_iter_num;
    end

    case ({wr_acc, rd_req})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (wr_req && !wr_acc) overflow_d = 1'b1;
  end

  // Control state registers with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      fir_valid_q <= 1'b0;
      fir_iter_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      fir_valid_q <= fir_valid_d;
      fir_iter_q  <= fir_iter_d;
    end
  end

  sigbuff_sdp_ram #(
    .DEPTH (MAX_SAMPLES_IN_RAM),
    .WIDTH (DATA_WIDTH)
  ) u_ram (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr_q),
    .wr_data (sel_data),
    .rd_en   (rd_req),
    .rd_addr (rd_ptr_q),
    .rd_data (fir_data)
  );

  assign sigbuff_ready    = not_full || rd_req;
  assign fir_valid        = fir_valid_q;
  assign fir_iter_num     = fir_iter_q;
  assign sigbuff_count    = count_q;
  assign sigbuff_overflow = overflow_q;

endmodule

// File: tb/tb_sigbuff_ctrl.sv
// Bench for sigbuff_ctrl: table vectors, directed corner sequences and a
// random run against a queue-based reference model (depths 255 and 5).
module tb_sigbuff_ctrl;
  import sigbuff_pkg::*;

  localparam int unsigned DA = 255;
  localparam int unsigned DB = 5;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  iter  = '0;
  logic        mux   = 1'b0;
  logic        ie    = 1'b0;
  logic        oe    = 1'b0;
  logic        lv    = 1'b0;
  logic        limv  = 1'b0;
  logic [15:0] ld    = '0;
  logic [15:0] limd  = '0;

  logic        a_ready, a_valid, a_ovf;
  logic [15:0] a_data;
  logic [4:0]  a_iter;
  logic [7:0]  a_count;
  logic        b_ready, b_valid, b_ovf;
  logic [15:0] b_data;
  logic [4:0]  b_iter;
  logic [2:0]  b_count;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: a bounded FIFO per instance.
  logic [15:0] mq [2][$];
  int unsigned cap [2];
  logic        m_valid [2];
  logic [15:0] m_data  [2];
  logic [4:0]  m_iter  [2];
  logic        m_ovf   [2];

  always #5 clock = ~clock;

  sigbuff_ctrl #(.MAX_SAMPLES_IN_RAM(DA), .DATA_WIDTH(16)) dut_a (
    .clock(clock), .reset(reset), .sigbuff_iter_num(iter),
    .sigbuff_input_mux(mux), .sigbuff_input_enable(ie),
    .sigbuff_output_enable(oe), .lvl_gen_data(ld), .lvl_gen_valid(lv),
    .limiter_data(limd), .limiter_valid(limv), .sigbuff_ready(a_ready),
    .fir_data(a_data), .fir_valid(a_valid), .fir_iter_num(a_iter),
    .sigbuff_count(a_count), .sigbuff_overflow(a_ovf)
  );

  sigbuff_ctrl #(.MAX_SAMPLES_IN_RAM(DB), .DATA_WIDTH(16)) dut_b (
    .clock(clock), .reset(reset), .sigbuff_iter_num(iter),
    .sigbuff_input_mux(mux), .sigbuff_input_enable(ie),
    .sigbuff_output_enable(oe), .lvl_gen_data(ld), .lvl_gen_valid(lv),
    .limiter_data(limd), .limiter_valid(limv), .sigbuff_ready(b_ready),
    .fir_data(b_data), .fir_valid(b_valid), .fir_iter_num(b_iter),
    .sigbuff_count(b_count), .sigbuff_overflow(b_ovf)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mq[k].delete();
      m_valid[k] = 1'b0;
      m_data[k]  = '0;
      m_iter[k]  = '0;
      m_ovf[k]   = 1'b0;
    end
  endtask

  function automatic logic exp_ready(input int k);
    return (mq[k].size() < cap[k]) || (oe && mq[k].size() != 0);
  endfunction

  // One clock of the model, using the inputs present at the edge.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin : per_inst
      logic        sv, rd, wr, acc;
      logic [15:0] sd;
      sv  = mux ? limv : lv;
      sd  = mux ? limd : ld;
      rd  = oe && (mq[k].size() != 0);
      wr  = ie && sv;
      acc = wr && ((mq[k].size() < cap[k]) || rd);
      m_valid[k] = rd;
      if (rd) begin
        m_data[k] = mq[k].pop_front();
        m_iter[k] = iter;
      end
      if (acc)     mq[k].push_back(sd);
      else if (wr) m_ovf[k] = 1'b1;
    end
  endtask

  task automatic check_regs();
    chk("a_valid", 32'(a_valid), 32'(m_valid[0]));
    chk("a_data",  32'(a_data),  32'(m_data[0]));
    chk("a_iter",  32'(a_iter),  32'(m_iter[0]));
    chk("a_count", 32'(a_count), 32'(mq[0].size()));
    chk("a_ovf",   32'(a_ovf),   32'(m_ovf[0]));
    chk("b_valid", 32'(b_valid), 32'(m_valid[1]));
    chk("b_data",  32'(b_data),  32'(m_data[1]));
    chk("b_iter",  32'(b_iter),  32'(m_iter[1]));
    chk("b_count", 32'(b_count), 32'(mq[1].size()));
    chk("b_ovf",   32'(b_ovf),   32'(m_ovf[1]));
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic tick();
    #1;
    chk("a_ready", 32'(a_ready), 32'(exp_ready(0)));
    chk("b_ready", 32'(b_ready), 32'(exp_ready(1)));
    @(posedge clock);
    model_step();
    @(negedge clock);
    check_regs();
  endtask

  task automatic idle();
    ie = 1'b0; oe = 1'b0; lv = 1'b0; limv = 1'b0; mux = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check_regs();
    chk("rst_a_ready", 32'(a_ready), 32'd1);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic wr_lvl(input logic [15:0] d);
    mux = 1'b0; ie = 1'b1; lv = 1'b1; ld = d; oe = 1'b0; limv = 1'b0;
    tick();
  endtask

  typedef struct {
    logic        ie, mux, lv;
    logic [15:0] ld;
    logic        limv;
    logic [15:0] limd;
    logic        oe;
    logic [4:0]  iter;
    logic        e_ready;
    logic [7:0]  e_count;
    logic        e_valid;
    logic [15:0] e_data;
    logic [4:0]  e_iter;
  } vec_t;

  vec_t tv [8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int oe_pct;
    int ie_pct;
    cap[0] = DA;
    cap[1] = DB;
    tv[0] = '{1'b1, 1'b0, 1'b1, 16'h0011, 1'b0, 16'h0000, 1'b0, 5'd0, 1'b1, 8'd1, 1'b0, 16'h0000, 5'd0};
    tv[1] = '{1'b1, 1'b0, 1'b1, 16'h0022, 1'b0, 16'h0000, 1'b1, 5'd0, 1'b1, 8'd1, 1'b1, 16'h0011, 5'd0};
    tv[2] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 5'd0, 1'b1, 8'd0, 1'b1, 16'h0022, 5'd0};
    tv[3] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0033, 1'b1, 5'd0, 1'b1, 8'd1, 1'b0, 16'h0022, 5'd0};
    tv[4] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0044, 1'b1, 5'd0, 1'b1, 8'd0, 1'b1, 16'h0033, 5'd0};
    tv[5] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0066, 1'b0, 5'd0, 1'b1, 8'd0, 1'b0, 16'h0033, 5'd0};
    tv[6] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0055, 1'b0, 5'd3, 1'b1, 8'd1, 1'b0, 16'h0033, 5'd0};
    tv[7] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 5'd7, 1'b1, 8'd0, 1'b1, 16'h0055, 5'd7};

    model_reset();
    @(negedge clock);
    check_regs();
    chk("rst_a_ready", 32'(a_ready), 32'd1);
    reset = 1'b0;

    // Table vectors, one clock per row.
    for (int i = 0; i < 8; i++) begin
      ie = tv[i].ie; mux = tv[i].mux; lv = tv[i].lv; ld = tv[i].ld;
      limv = tv[i].limv; limd = tv[i].limd; oe = tv[i].oe; iter = tv[i].iter;
      #1;
      chk("tv_ready", 32'(a_ready), 32'(tv[i].e_ready));
      tick();
      chk("tv_count", 32'(a_count), 32'(tv[i].e_count));
      chk("tv_valid", 32'(a_valid), 32'(tv[i].e_valid));
      chk("tv_data",  32'(a_data),  32'(tv[i].e_data));
      chk("tv_iter",  32'(a_iter),  32'(tv[i].e_iter));
    end
    idle();
    iter = '0;

    // Fill to depth, then overflow attempt, then drain.
    do_reset();
    for (int i = 0; i < 255; i++) wr_lvl(16'(i));
    chk("fill_count", 32'(a_count), 32'd255);
    idle();
    #1;
    chk("fill_ready", 32'(a_ready), 32'd0);
    ie = 1'b1; lv = 1'b1; ld = 16'hABCD;
    tick();
    chk("ovf_flag", 32'(a_ovf), 32'd1);
    chk("ovf_count", 32'(a_count), 32'd255);
    idle();
    repeat (3) tick();
    chk("ovf_sticky", 32'(a_ovf), 32'd1);
    oe = 1'b1;
    for (int i = 0; i < 255; i++) begin
      tick();
      chk("drain_valid", 32'(a_valid), 32'd1);
      chk("drain_data",  32'(a_data),  32'(i));
    end
    tick();
    chk("drain_end_valid", 32'(a_valid), 32'd0);
    chk("drain_end_count", 32'(a_count), 32'd0);
    idle();

    // Full buffer with simultaneous limiter write and read.
    do_reset();
    for (int i = 0; i < 255; i++) wr_lvl(16'($urandom));
    lv = 1'b0; mux = 1'b1; limv = 1'b1; ie = 1'b1; oe = 1'b1;
    for (int i = 0; i < 10; i++) begin
      limd = 16'h1000 + 16'(i);
      tick();
      chk("rw_full_count", 32'(a_count), 32'd255);
      chk("rw_full_valid", 32'(a_valid), 32'd1);
    end
    chk("rw_full_ovf", 32'(a_ovf), 32'd0);
    ie = 1'b0; limv = 1'b0;
    for (int i = 0; i < 255; i++) begin
      tick();
      if (i >= 245) chk("rw_full_tail", 32'(a_data), 32'h1000 + 32'(i - 245));
    end
    idle();

    // Pointer wrap on the depth-5 instance.
    do_reset();
    for (int i = 0; i < 3; i++) wr_lvl(16'(i + 1));
    idle(); oe = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wrap_pre_data", 32'(b_data), 32'(i + 1));
    end
    for (int i = 0; i < 5; i++) wr_lvl(16'(10 + i));
    chk("wrap_count", 32'(b_count), 32'd5);
    idle();
    #1;
    chk("wrap_full_ready", 32'(b_ready), 32'd0);
    oe = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("wrap_valid", 32'(b_valid), 32'd1);
      chk("wrap_data",  32'(b_data),  32'(10 + i));
    end
    idle();

    // Iteration tag follows the read-request cycle.
    do_reset();
    wr_lvl(16'h0077);
    wr_lvl(16'h0088);
    idle(); oe = 1'b1; iter = 5'd0;
    tick();
    chk("tag0_iter", 32'(a_iter), 32'd0);
    chk("tag0_data", 32'(a_data), 32'h0077);
    iter = 5'd1;
    tick();
    chk("tag1_iter", 32'(a_iter), 32'd1);
    chk("tag1_valid", 32'(a_valid), 32'd1);
    chk("tag1_data", 32'(a_data), 32'h0088);
    idle(); iter = '0;

    // Asynchronous reset while streaming.
    do_reset();
    for (int i = 0; i < 20; i++) wr_lvl(16'h0200 + 16'(i));
    idle(); oe = 1'b1;
    repeat (3) tick();
    chk("async_pre_valid", 32'(a_valid), 32'd1);
    reset = 1'b1;
    #1;
    chk("async_valid", 32'(a_valid), 32'd0);
    chk("async_count", 32'(a_count), 32'd0);
    chk("async_data",  32'(a_data),  32'd0);
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    idle();
    #1;
    chk("async_ready", 32'(a_ready), 32'd1);
    wr_lvl(16'h5A5A);
    idle(); oe = 1'b1;
    tick();
    chk("async_rd_valid", 32'(a_valid), 32'd1);
    chk("async_rd_data",  32'(a_data),  32'h5A5A);
    idle();

    // Random traffic against the model.
    oe_pct = 50;
    ie_pct = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) begin
        oe_pct = 10 + 40 * int'($urandom_range(0, 2));
        ie_pct = 10 + 40 * int'($urandom_range(0, 2));
      end
      if ($urandom_range(0, 599) == 0) begin
        idle();
        do_reset();
      end
      ie   = ($urandom_range(0, 99) < ie_pct);
      oe   = ($urandom_range(0, 99) < oe_pct);
      mux  = 1'($urandom);
      lv   = 1'($urandom);
      limv = 1'($urandom);
      ld   = 16'($urandom);
      limd = 16'($urandom);
      iter = 5'($urandom);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
